// File: rtl/pwm_frame_sequencer.sv
// Double-buffered PWM frame sequencer: collects STAGE duty words, streams them to the
// channel latch at each period boundary and paces the global PWM counter.
//
// state | meaning
// IDLE  | waiting for enable and a full shadow frame
// LOAD  | streaming active[k] to the latch, k = 0..STAGE-1
// SYNC  | frame_sync pulse, latch commit, counters cleared
// RUN   | prescaled ticks until the period counter wraps
module pwm_frame_sequencer #(
    parameter int DWIDTH   = 8,
    parameter int STAGE    = 8,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              load_start,
    output logic [DWIDTH-1:0] load_data,
    output logic              cnt_tick,
    output logic              frame_sync,
    output logic              busy,
    output logic              underrun,
    output logic [15:0]       frame_cnt
);

    localparam int IW = $clog2(STAGE + 1);
    localparam int KW = (STAGE > 1) ? $clog2(STAGE) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] FILL_FULL = IW'(STAGE);
    localparam logic [KW-1:0] K_LAST    = KW'(STAGE - 1);
    localparam logic [PW-1:0] P_LAST    = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SYNC, RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DWIDTH-1:0] shadow [STAGE];
    logic [DWIDTH-1:0] active [STAGE];
    logic [IW-1:0]     fill_idx;
    logic [KW-1:0]     load_idx;
    logic [PW-1:0]     pre_cnt;
    logic [DWIDTH-1:0] period_cnt;
    logic              full;
    logic              xfer;
    logic              boundary;
    logic              copy;

    assign full       = (fill_idx == FILL_FULL);
    assign in_ready   = (fill_idx < FILL_FULL);
    assign xfer       = in_valid & in_ready;
    assign cnt_tick   = (state == RUN) && (pre_cnt == P_LAST);
    assign boundary   = cnt_tick && (period_cnt == '1);
    assign busy       = (state != IDLE);
    assign load_start = (state == LOAD) && (load_idx == '0);
    assign frame_sync = (state == SYNC);
    // Outside LOAD the last streamed word stays on the bus.
    assign load_data  = active[(state == LOAD) ? load_idx : K_LAST];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        copy      = 1'b0;
        underrun  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && full) begin
                    state_nxt = LOAD;
                    copy      = 1'b1;
                end
            end
            LOAD: begin
                if (load_idx == K_LAST) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: state_nxt = RUN;
            RUN: begin
                if (boundary) begin
                    if (!enable) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = LOAD;
                        // Without a fresh frame the active buffer is streamed again.
                        if (full) begin
                            copy = 1'b1;
                        end else begin
                            underrun = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGE; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            fill_idx   <= '0;
            load_idx   <= '0;
            pre_cnt    <= '0;
            period_cnt <= '0;
            frame_cnt  <= '0;
        end else begin
            if (copy) begin
                active   <= shadow;
                fill_idx <= xfer ? IW'(1) : '0;
                if (xfer) begin
                    shadow[0] <= in_data;
                end
            end else if (xfer) begin
                shadow[fill_idx[KW-1:0]] <= in_data;
                fill_idx                 <= fill_idx + 1'b1;
            end

            if (state == LOAD) begin
                load_idx <= (load_idx == K_LAST) ? '0 : load_idx + 1'b1;
            end else begin
                load_idx <= '0;
            end

            // frame_cnt already shows the new count while frame_sync is high.
            if ((state == LOAD) && (load_idx == K_LAST)) begin
                frame_cnt <= frame_cnt + 1'b1;
            end

            if (state == SYNC) begin
                pre_cnt    <= '0;
                period_cnt <= '0;
            end else if (state == RUN) begin
                pre_cnt <= cnt_tick ? '0 : pre_cnt + 1'b1;
                if (cnt_tick) begin
                    period_cnt <= period_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// Scoreboard bench for pwm_frame_sequencer: stimulus queues expected load words,
// underrun flags and frame counts; a negedge monitor pops and compares them.
module tb_pwm_frame_sequencer;

    localparam int ST    = 8;
    localparam int PS    = 4;
    localparam int TICKS = 256;
    localparam int SPAN  = TICKS * PS + 1;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        enable   = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready;
    logic        load_start;
    logic [7:0]  load_data;
    logic        cnt_tick;
    logic        frame_sync;
    logic        busy;
    logic        underrun;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_words [$];
    bit          exp_ur    [$];
    logic [15:0] exp_fc    [$];

    int cyc = 0, start_cyc = 0, sync_cyc = 0, ticks = 0, k = 0, syncs = 0;
    bit in_load = 0, period_active = 0, ur_prev = 0;

    pwm_frame_sequencer #(.DWIDTH(8), .STAGE(ST), .PRESCALE(PS)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_start (load_start),
        .load_data  (load_data),
        .cnt_tick   (cnt_tick),
        .frame_sync (frame_sync),
        .busy       (busy),
        .underrun   (underrun),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int value);
        checks++;
        errors++;
        $display("FAIL %s value=%0d", name, value);
    endtask

    task automatic push_word(input logic [7:0] w);
        int t = 0;
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) fail_now("push_timeout", t);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] base, input bit ur, input logic [15:0] fc);
        for (int i = 0; i < ST; i++) exp_words.push_back(base + 8'(i));
        exp_ur.push_back(ur);
        exp_fc.push_back(fc);
    endtask

    task automatic wait_syncs(input int n, input int lim);
        int t = 0;
        while (syncs < n && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (syncs < n) fail_now("frame_sync_timeout", syncs);
    endtask

    task automatic wait_idle(input int lim);
        int t = 0;
        while (busy && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (busy) fail_now("idle_timeout", t);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            in_load       = 0;
            period_active = 0;
            ur_prev       = 0;
        end else begin
            cyc++;
            if (load_start) begin
                if (exp_ur.size() == 0) fail_now("unexpected_load_start", cyc);
                else chk("underrun_before_load", 32'(ur_prev), 32'(exp_ur.pop_front()));
                if (period_active) begin
                    chk("ticks_per_period", ticks, TICKS);
                    chk("period_span", cyc - sync_cyc, SPAN);
                    period_active = 0;
                end
                in_load   = 1;
                k         = 0;
                start_cyc = cyc;
            end
            if (in_load) begin
                if (exp_words.size() == 0) fail_now("unexpected_load_word", cyc);
                else chk("load_data", 32'(load_data), 32'(exp_words.pop_front()));
                k++;
                if (k == ST) in_load = 0;
            end
            if (cnt_tick) begin
                if (!period_active) fail_now("tick_outside_run", cyc);
                ticks++;
            end
            if (frame_sync) begin
                chk("sync_latency", cyc - start_cyc, ST);
                if (exp_fc.size() == 0) fail_now("unexpected_frame_sync", cyc);
                else chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc.pop_front()));
                period_active = 1;
                ticks         = 0;
                sync_cyc      = cyc;
                syncs++;
            end else if (period_active && !busy) begin
                chk("ticks_last_period", ticks, TICKS);
                chk("last_period_span", cyc - sync_cyc, SPAN);
                period_active = 0;
            end
            ur_prev = underrun;
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({load_start, cnt_tick, frame_sync, busy, underrun, load_data, frame_cnt}), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        rst    = 1'b1;
        enable = 1'b1;

        // Frame 1 from IDLE.
        expect_frame(8'h10, 1'b0, 16'd1);
        for (int i = 0; i < ST; i++) push_word(8'h10 + 8'(i));
        chk("in_ready_after_full", 32'(in_ready), 32'h0);
        @(negedge clk);
        chk("first_load_start", 32'(load_start), 32'h1);

        // Frame 2 arrives during LOAD/RUN; frame 3 is an underrun re-stream of frame 2.
        expect_frame(8'hA0, 1'b0, 16'd2);
        for (int i = 0; i < ST; i++) push_word(8'hA0 + 8'(i));
        expect_frame(8'hA0, 1'b1, 16'd3);
        wait_syncs(3, 5000);

        // Drop enable mid-period; the period must still finish.
        repeat (500) @(negedge clk);
        enable = 1'b0;
        chk("busy_after_enable_drop", 32'(busy), 32'h1);
        wait_idle(3000);
        repeat (40) @(negedge clk);
        chk("idle_after_period", 32'(busy), 32'h0);

        // Abort a LOAD at k=3 with reset.
        enable = 1'b1;
        exp_words.push_back(8'h30);
        exp_words.push_back(8'h31);
        exp_words.push_back(8'h32);
        exp_ur.push_back(1'b0);
        for (int i = 0; i < ST; i++) push_word(8'h30 + 8'(i));
        t = 0;
        while (!load_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!load_start) fail_now("load_start_timeout", t);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midload_rst_outputs", 32'({load_start, cnt_tick, frame_sync, busy, underrun, load_data, frame_cnt}), 32'h0);
        chk("midload_rst_in_ready", 32'(in_ready), 32'h1);
        exp_words.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_load_after_rst", 32'(busy), 32'h0);

        // Seven words are not enough; the eighth starts the load.
        for (int i = 0; i < ST - 1; i++) push_word(8'h40 + 8'(i));
        repeat (20) @(negedge clk);
        chk("partial_frame_idle", 32'(busy), 32'h0);
        chk("partial_frame_ready", 32'(in_ready), 32'h1);
        expect_frame(8'h40, 1'b0, 16'd1);
        push_word(8'h47);
        chk("in_ready_after_refill", 32'(in_ready), 32'h0);
        @(negedge clk);
        chk("load_start_after_refill", 32'(load_start), 32'h1);
        wait_syncs(4, 100);
        enable = 1'b0;
        wait_idle(3000);
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_words.size() + exp_ur.size() + exp_fc.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
